// File: rtl/object_compositor_if.sv
// object_compositor_if: config, pixel-in and RGB-out signals of the object compositor
interface object_compositor_if #(
  parameter int NUM_OBJ = 16,
  parameter int COORD_W = 10
);
  localparam int IDX_W = $clog2(NUM_OBJ);
  logic               cfg_we;
  logic [IDX_W-1:0]   cfg_idx;
  logic [COORD_W-1:0] cfg_x, cfg_y, cfg_hx, cfg_hy;
  logic               cfg_shape;
  logic [23:0]        cfg_color;
  logic               cfg_en;
  logic               frame_start;
  logic               pix_valid;
  logic [COORD_W-1:0] DrawX, DrawY;
  logic               blank;
  logic               out_valid;
  logic [7:0]         Red, Green, Blue;
  logic [IDX_W-1:0]   hit_idx;
  logic               hit;
  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, cfg_hx, cfg_hy, cfg_shape, cfg_color, cfg_en,
    output frame_start, pix_valid, DrawX, DrawY, blank,
    input  out_valid, Red, Green, Blue, hit_idx, hit
  );
  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, cfg_hx, cfg_hy, cfg_shape, cfg_color, cfg_en,
    input  frame_start, pix_valid, DrawX, DrawY, blank,
    output out_valid, Red, Green, Blue, hit_idx, hit
  );
endinterface

// File: rtl/object_compositor.sv
// object_compositor: 3-stage per-pixel compositor over double-buffered object slots, lowest index wins
module object_compositor #(
  parameter int          NUM_OBJ = 16,
  parameter int          COORD_W = 10,
  parameter logic [23:0] BG_RGB  = 24'h70707F
) (
  input logic Clk,
  input logic Reset,
  object_compositor_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_OBJ);
  localparam int SQ_W  = 2*COORD_W+2;
  typedef struct packed {
    logic [COORD_W-1:0] x, y, hx, hy;
    logic               shape;
    logic [23:0]        color;
    logic               en;
  } slot_t;
  typedef struct packed {
    logic [COORD_W:0]   dx, dy;
    logic [COORD_W-1:0] hx, hy;
    logic               shape, en;
    logic [23:0]        color;
  } geo_t;
  slot_t              sh_q[NUM_OBJ], sh_d[NUM_OBJ], act_q[NUM_OBJ];
  geo_t               s1_q[NUM_OBJ];
  logic [23:0]        col2_q[NUM_OBJ];
  logic [COORD_W:0]   adx[NUM_OBJ], ady[NUM_OBJ];
  logic [NUM_OBJ-1:0] hit_d, hit2_q;
  logic               v1_q, v2_q, b1_q, b2_q;
  logic [IDX_W-1:0]   sel_d, idx_q;
  logic               ov_q, hit_q;
  logic [23:0]        rgb_q;

  // a write in the commit cycle is folded into the committed bank
  always_comb begin
    sh_d = sh_q;
    if (bus.cfg_we && 32'(bus.cfg_idx) < NUM_OBJ)
      sh_d[bus.cfg_idx] = '{x: bus.cfg_x, y: bus.cfg_y, hx: bus.cfg_hx, hy: bus.cfg_hy,
                            shape: bus.cfg_shape, color: bus.cfg_color, en: bus.cfg_en};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      sh_q <= sh_d;
      if (bus.frame_start) act_q <= sh_d;
    end
  end

  // differences carry a sign bit so objects near the edges clip instead of aliasing
  always_ff @(posedge Clk) begin
    b1_q <= bus.blank;
    b2_q <= b1_q;
    hit2_q <= hit_d;
    for (int i = 0; i < NUM_OBJ; i++) begin
      s1_q[i] <= '{dx: {1'b0, bus.DrawX} - {1'b0, act_q[i].x},
                   dy: {1'b0, bus.DrawY} - {1'b0, act_q[i].y},
                   hx: act_q[i].hx, hy: act_q[i].hy, shape: act_q[i].shape,
                   en: act_q[i].en, color: act_q[i].color};
      col2_q[i] <= s1_q[i].color;
    end
  end

  always_comb begin
    hit_d = '0;
    adx = '{default: '0};
    ady = '{default: '0};
    for (int i = 0; i < NUM_OBJ; i++) begin
      adx[i] = s1_q[i].dx[COORD_W] ? -s1_q[i].dx : s1_q[i].dx;
      ady[i] = s1_q[i].dy[COORD_W] ? -s1_q[i].dy : s1_q[i].dy;
      hit_d[i] = s1_q[i].en && (s1_q[i].shape
        ? (SQ_W'(adx[i]) * SQ_W'(adx[i]) + SQ_W'(ady[i]) * SQ_W'(ady[i])
           <= SQ_W'(s1_q[i].hx) * SQ_W'(s1_q[i].hx))
        : (adx[i] <= {1'b0, s1_q[i].hx} && ady[i] <= {1'b0, s1_q[i].hy}));
    end
  end

  always_comb begin
    sel_d = '0;
    for (int i = NUM_OBJ-1; i >= 0; i--)
      if (hit2_q[i]) sel_d = IDX_W'(i);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      ov_q  <= 1'b0;
      rgb_q <= '0;
      hit_q <= 1'b0;
      idx_q <= '0;
    end else begin
      v1_q <= bus.pix_valid;
      v2_q <= v1_q;
      ov_q <= v2_q;
      if (v2_q) begin
        rgb_q <= !b2_q ? 24'h0 : (|hit2_q) ? col2_q[sel_d] : BG_RGB;
        hit_q <= |hit2_q;
        idx_q <= sel_d;
      end
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.Red       = rgb_q[23:16];
  assign bus.Green     = rgb_q[15:8];
  assign bus.Blue      = rgb_q[7:0];
  assign bus.hit       = hit_q;
  assign bus.hit_idx   = idx_q;
endmodule

// File: tb/tb_object_compositor.sv
// tb_object_compositor: directed checks of compositing, priority, clipping and double buffering
module tb_object_compositor;
  localparam int N  = 16;
  localparam int CW = 10;
  localparam logic [23:0] BG = 24'h70707F;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int tests = 0;
  int fails = 0;

  object_compositor_if #(.NUM_OBJ(N), .COORD_W(CW)) bus ();
  object_compositor #(.NUM_OBJ(N), .COORD_W(CW), .BG_RGB(BG)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int hx, input int hy,
                    input logic shape, input logic [23:0] c, input logic en, input logic commit);
    bus.cfg_we = 1'b1;
    bus.cfg_idx = 4'(idx);
    bus.cfg_x = CW'(x);
    bus.cfg_y = CW'(y);
    bus.cfg_hx = CW'(hx);
    bus.cfg_hy = CW'(hy);
    bus.cfg_shape = shape;
    bus.cfg_color = c;
    bus.cfg_en = en;
    bus.frame_start = commit;
    step();
    bus.cfg_we = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic commit();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] rgb, input logic h, input int idx);
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_rgb"}, 32'({bus.Red, bus.Green, bus.Blue}), 32'(rgb));
    chk({tag, "_hit"}, 32'(bus.hit), 32'(h));
    chk({tag, "_idx"}, 32'(bus.hit_idx), 32'(idx));
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic b,
                     input logic [23:0] rgb, input logic h, input int idx);
    bus.DrawX = CW'(x);
    bus.DrawY = CW'(y);
    bus.blank = b;
    bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0;
    step();
    chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    step();
    chk_out(tag, rgb, h, idx);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0;
    bus.cfg_hx = '0; bus.cfg_hy = '0; bus.cfg_shape = 1'b0; bus.cfg_color = '0;
    bus.cfg_en = 1'b0; bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0;
    step();
    step();
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
    chk("rst_hit", 32'(bus.hit), 32'd0);
    chk("rst_idx", 32'(bus.hit_idx), 32'd0);
    Reset = 1'b0;
    commit();
    pix("bg", 100, 100, 1'b1, BG, 1'b0, 0);

    wr(0, 320, 240, 10, 5, 1'b0, 24'hFF0000, 1'b1, 1'b1);
    pix("rect_corner", 330, 245, 1'b1, 24'hFF0000, 1'b1, 0);
    pix("rect_outx", 331, 245, 1'b1, BG, 1'b0, 0);
    pix("rect_outy", 320, 246, 1'b1, BG, 1'b0, 0);

    wr(3, 50, 50, 5, 0, 1'b1, 24'h0000FF, 1'b1, 1'b1);
    pix("circ_edge", 54, 53, 1'b1, 24'h0000FF, 1'b1, 3);
    pix("circ_out", 54, 54, 1'b1, BG, 1'b0, 0);
    pix("circ_left", 45, 50, 1'b1, 24'h0000FF, 1'b1, 3);
    wr(3, 2, 2, 5, 0, 1'b1, 24'h0000FF, 1'b1, 1'b1);
    pix("clip_origin", 0, 0, 1'b1, 24'h0000FF, 1'b1, 3);
    pix("no_alias", 1020, 1020, 1'b1, BG, 1'b0, 0);

    wr(2, 600, 400, 0, 0, 1'b0, 24'h123456, 1'b1, 1'b1);
    pix("pt_hit", 600, 400, 1'b1, 24'h123456, 1'b1, 2);
    pix("pt_miss", 601, 400, 1'b1, BG, 1'b0, 0);

    wr(1, 200, 200, 3, 3, 1'b0, 24'h00FF00, 1'b1, 1'b0);
    wr(5, 200, 200, 4, 0, 1'b1, 24'hFFFF00, 1'b1, 1'b1);
    pix("ovl_lo", 200, 200, 1'b1, 24'h00FF00, 1'b1, 1);
    step();
    chk("hold_ov", 32'(bus.out_valid), 32'd0);
    chk("hold_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h00FF00);
    wr(1, 200, 200, 3, 3, 1'b0, 24'h00FF00, 1'b0, 1'b1);
    pix("ovl_dis", 200, 200, 1'b1, 24'hFFFF00, 1'b1, 5);

    wr(0, 100, 300, 10, 5, 1'b0, 24'hFF0000, 1'b1, 1'b0);
    pix("shadow_old", 320, 240, 1'b1, 24'hFF0000, 1'b1, 0);
    pix("shadow_new", 100, 300, 1'b1, BG, 1'b0, 0);
    bus.DrawX = CW'(100); bus.DrawY = CW'(300); bus.blank = 1'b1;
    bus.pix_valid = 1'b1;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    step();
    bus.pix_valid = 1'b0;
    step();
    chk_out("commit_same", BG, 1'b0, 0);
    step();
    chk_out("commit_next", 24'hFF0000, 1'b1, 0);

    wr(0, 500, 100, 2, 2, 1'b0, 24'h00FFFF, 1'b1, 1'b1);
    pix("wr_commit", 500, 100, 1'b1, 24'h00FFFF, 1'b1, 0);
    pix("blank_obj", 500, 100, 1'b0, 24'h000000, 1'b1, 0);

    bus.DrawX = CW'(500); bus.DrawY = CW'(100); bus.blank = 1'b1;
    bus.pix_valid = 1'b1;
    step();
    step();
    Reset = 1'b1;
    bus.pix_valid = 1'b0;
    step();
    Reset = 1'b0;
    chk("mrst_ov", 32'(bus.out_valid), 32'd0);
    chk("mrst_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'd0);
    chk("mrst_hit", 32'(bus.hit), 32'd0);
    step();
    chk("flush_ov1", 32'(bus.out_valid), 32'd0);
    step();
    chk("flush_ov2", 32'(bus.out_valid), 32'd0);
    pix("mrst_act", 500, 100, 1'b1, BG, 1'b0, 0);
    commit();
    pix("mrst_shadow", 500, 100, 1'b1, BG, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
